// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display digit interface.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Digit code that display logic drives into the decoder to show a minus sign or dash.
  localparam logic [DIGIT_W-1:0] BCD_DASH = 4'hA;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_c_o
);

  assign d_c_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned DIGITS   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic [IN_WIDTH-1:0]         bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                        neg
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam int unsigned SR_W  = BCD_W + IN_WIDTH;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_pend_q, neg_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                neg_q, neg_d;

  logic [BCD_W-1:0]    adj_c;
  logic [SR_W-1:0]     shifted_c;
  logic                accept_c;
  logic                in_neg_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i   (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .d_c_o (adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted_c = {adj_c, mag_q} << 1;
  assign in_neg_c  = signed_mode & bin_in[IN_WIDTH-1];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    accept_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept_c = start;
      end
      SHIFT: begin
        scratch_d = shifted_c[SR_W-1 -: BCD_W];
        mag_d     = shifted_c[IN_WIDTH-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        // Publish the finished digits; a new request may be accepted on the same edge.
        bcd_d    = scratch_q;
        neg_d    = neg_pend_q;
        done_d   = 1'b1;
        accept_c = start;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      mag_d      = in_neg_c ? IN_WIDTH'(~bin_in + IN_WIDTH'(1)) : bin_in;
      neg_pend_d = in_neg_c;
      cnt_d      = CNT_W'(IN_WIDTH);
      scratch_d  = '0;
      state_d    = SHIFT;
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: arithmetic reference model plus directed and random conversions.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  bin_in = 8'h00;
  logic        busy, done, neg;
  logic [11:0] bcd_out;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .neg         (neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of the magnitude, computed with plain integer arithmetic.
  function automatic logic [11:0] to_bcd(input logic [7:0] b, input logic sm);
    int m;
    m = (sm && b[7]) ? 256 - int'(b) : int'(b);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Reference model: phase counts edges since acceptance; -1 means no conversion in flight.
  int          phase = -1;
  logic [11:0] pend_bcd = '0, exp_bcd = '0;
  logic        pend_neg = 1'b0, exp_neg = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int          p;
    logic [11:0] pb, eb;
    logic        pn, en, ed;
    if (!rst_n) begin
      phase    <= -1;
      pend_bcd <= '0;
      pend_neg <= 1'b0;
      exp_bcd  <= '0;
      exp_neg  <= 1'b0;
      exp_done <= 1'b0;
      exp_busy <= 1'b0;
    end else begin
      p = phase; pb = pend_bcd; pn = pend_neg; eb = exp_bcd; en = exp_neg; ed = 1'b0;
      if (p == 8) begin
        ed = 1'b1; eb = pb; en = pn; p = -1;
      end else if (p >= 0) begin
        p++;
      end
      if (p == -1 && start) begin
        pb = to_bcd(bin_in, signed_mode);
        pn = signed_mode && bin_in[7];
        p  = 0;
      end
      phase    <= p;
      pend_bcd <= pb;
      pend_neg <= pn;
      exp_bcd  <= eb;
      exp_neg  <= en;
      exp_done <= ed;
      exp_busy <= (p >= 0 && p < 8);
    end
  end

  always @(negedge clk) begin
    logic [3:0] dig;
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    check("neg", 32'(neg), 32'(exp_neg));
    for (int i = 0; i < 3; i++) begin
      dig = bcd_out[4*i +: 4];
      checks++;
      if (dig > 4'd9 || dig == BCD_DASH) begin
        errors++;
        $display("FAIL digit_range: digit %0d got %0h expected 0..9", i, dig);
      end
    end
  end

  // Waits for done, counting edges from the current point and busy cycles seen.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = busy ? 1 : 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end while (!done && n < 30);
    if (!done) check("done_timeout", 32'(n), 32'(9));
  endtask

  task automatic run(input logic [7:0] b, input logic sm, input logic [11:0] lit_bcd,
                     input logic lit_neg);
    int n, bc;
    @(negedge clk);
    start = 1'b1; bin_in = b; signed_mode = sm;
    @(negedge clk);
    start = 1'b0; bin_in = 8'($urandom); signed_mode = 1'($urandom);
    wait_done(n, bc);
    check("latency", 32'(n), 32'(9));
    check("busy_cycles", 32'(bc), 32'(8));
    check("lit_bcd", 32'(bcd_out), 32'(lit_bcd));
    check("lit_neg", 32'(neg), 32'(lit_neg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, extra;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_bcd", 32'(bcd_out), 32'(0));
    check("rst_neg", 32'(neg), 32'(0));
    rst_n = 1'b1;

    run(8'h00, 1'b0, 12'h000, 1'b0);
    run(8'hFF, 1'b0, 12'h255, 1'b0);
    run(8'h80, 1'b0, 12'h128, 1'b0);
    run(8'h09, 1'b0, 12'h009, 1'b0);
    run(8'h80, 1'b1, 12'h128, 1'b1);
    run(8'hFF, 1'b1, 12'h001, 1'b1);
    run(8'h7F, 1'b1, 12'h127, 1'b0);
    run(8'h00, 1'b1, 12'h000, 1'b0);

    // Requests during SHIFT must be ignored.
    @(negedge clk);
    start = 1'b1; bin_in = 8'h2A; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; bin_in = 8'h11;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    check("ignored_start_bcd", 32'(bcd_out), 32'(12'h042));
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored_start_dones", 32'(extra), 32'(0));

    // Back-to-back conversions with start held high.
    @(negedge clk);
    start = 1'b1; bin_in = 8'd200; signed_mode = 1'b0;
    @(negedge clk);
    bin_in = 8'd37;
    wait_done(n, bc);
    check("b2b_first_latency", 32'(n), 32'(9));
    check("b2b_first_bcd", 32'(bcd_out), 32'(12'h200));
    start = 1'b0;
    wait_done(n, bc);
    check("b2b_period", 32'(n), 32'(9));
    check("b2b_second_bcd", 32'(bcd_out), 32'(12'h037));

    // Asynchronous reset in the middle of a conversion.
    run(8'hFF, 1'b0, 12'h255, 1'b0);
    @(negedge clk);
    start = 1'b1; bin_in = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_done", 32'(done), 32'(0));
    check("async_rst_bcd", 32'(bcd_out), 32'(0));
    check("async_rst_neg", 32'(neg), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h64, 1'b0, 12'h100, 1'b0);

    // Random traffic checked cycle by cycle against the model.
    repeat (400) begin
      @(negedge clk);
      start       = ($urandom_range(0, 3) == 0);
      bin_in      = 8'($urandom);
      signed_mode = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
